// File: rtl/hazard_unit_sb_if.sv
// Pipeline-side bundle for the hazard/forward unit: operand tags, forwarding
// sources, long-latency issue, stall causes and the resulting selects/stalls.
interface hazard_unit_sb_if #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned LAT_W   = 6
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC + 2);

    logic [7:0]               hazards;
    logic [REG_W-1:0]         id_rs;
    logic [REG_W-1:0]         id_rt;
    logic [REG_W-1:0]         ex_rs;
    logic [REG_W-1:0]         ex_rt;
    logic [REG_W-1:0]         ex_dst;
    logic                     ex_regwrite;
    logic                     ex_link;
    logic [NUM_SRC*REG_W-1:0] src_dst;
    logic [NUM_SRC-1:0]       src_regwrite;
    logic [NUM_SRC-1:0]       src_ready;
    logic                     lat_issue;
    logic [LAT_W-1:0]         lat_cycles;
    logic                     imem_read_en;
    logic                     imem_ack;
    logic                     alu_stall;
    logic                     mem_ctrl_stall;

    logic [SEL_W-1:0]         ex_rs_sel;
    logic [SEL_W-1:0]         ex_rt_sel;
    logic                     if_stall;
    logic                     id_stall;
    logic                     ex_stall;
    logic                     m_stall;
    logic                     wb_stall;
    logic                     lat_done;
    logic [REG_W-1:0]         lat_done_dst;
    logic                     sb_full;
    logic [31:0]              stall_cnt;

    modport master (
        output hazards, id_rs, id_rt, ex_rs, ex_rt, ex_dst, ex_regwrite, ex_link,
               src_dst, src_regwrite, src_ready, lat_issue, lat_cycles,
               imem_read_en, imem_ack, alu_stall, mem_ctrl_stall,
        input  ex_rs_sel, ex_rt_sel, if_stall, id_stall, ex_stall, m_stall, wb_stall,
               lat_done, lat_done_dst, sb_full, stall_cnt
    );

    modport slave (
        input  hazards, id_rs, id_rt, ex_rs, ex_rt, ex_dst, ex_regwrite, ex_link,
               src_dst, src_regwrite, src_ready, lat_issue, lat_cycles,
               imem_read_en, imem_ack, alu_stall, mem_ctrl_stall,
        output ex_rs_sel, ex_rt_sel, if_stall, id_stall, ex_stall, m_stall, wb_stall,
               lat_done, lat_done_dst, sb_full, stall_cnt
    );
endinterface

// File: rtl/hazard_unit_sb.sv
// Hazard/forwarding controller with NUM_SRC ordered bypass sources, a scoreboard
// of pending long-latency writes, and a saturating id_stall cycle counter.
module hazard_unit_sb #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned SB_DEPTH = 4,
    parameter int unsigned LAT_W    = 6
) (
    input logic              clock,
    input logic              reset,
    hazard_unit_sb_if.slave  bus
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC + 2);
    localparam int unsigned IDX_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam logic [SEL_W-1:0] SEL_LINK = '1;

    logic [SB_DEPTH-1:0] sb_valid;
    logic [REG_W-1:0]    sb_dst [SB_DEPTH];
    logic [LAT_W-1:0]    sb_cnt [SB_DEPTH];
    logic [31:0]         stall_cnt;

    logic [SEL_W:0]      rs_fwd, rt_fwd;
    logic                id_hz, ex_hz, sb_stall, sb_full, waw;
    logic                id_rs_busy, id_rt_busy, ex_rs_sb, ex_rt_sb;
    logic                free_found, ret_found;
    logic [IDX_W-1:0]    free_idx, ret_idx;
    logic                if_stall, m_stall, ex_stall, id_stall, issue, lat_done;

    // Returns {ex_hz contribution, select}; only the youngest matching source counts.
    function automatic logic [SEL_W:0] fwd(
        input logic [REG_W-1:0]         r,
        input logic                     use_op,
        input logic                     need,
        input logic [NUM_SRC*REG_W-1:0] dsts,
        input logic [NUM_SRC-1:0]       wr,
        input logic [NUM_SRC-1:0]       rdy
    );
        logic             found;
        logic             hz;
        logic [SEL_W-1:0] sel;
        found = 1'b0;
        hz    = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found && wr[k] && dsts[k*REG_W +: REG_W] == r && r != '0) begin
                found = 1'b1;
                if (rdy[k]) begin
                    if (use_op) sel = SEL_W'(k + 1);
                end else begin
                    hz = need;
                end
            end
        end
        return {hz, sel};
    endfunction

    // Any source (not just the youngest) still waiting on memory blocks ID.
    function automatic logic src_busy(
        input logic [REG_W-1:0]         r,
        input logic [NUM_SRC*REG_W-1:0] dsts,
        input logic [NUM_SRC-1:0]       wr,
        input logic [NUM_SRC-1:0]       rdy
    );
        logic busy;
        busy = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++)
            if (wr[k] && !rdy[k] && dsts[k*REG_W +: REG_W] == r && r != '0) busy = 1'b1;
        return busy;
    endfunction

    always_comb begin
        logic id_need_rs, id_need_rt;
        logic ex_hit_rs, ex_hit_rt, sb_hit_rs, sb_hit_rt;

        rs_fwd = fwd(bus.ex_rs, bus.hazards[3] | bus.hazards[2], bus.hazards[2],
                     bus.src_dst, bus.src_regwrite, bus.src_ready);
        rt_fwd = fwd(bus.ex_rt, bus.hazards[1] | bus.hazards[0], bus.hazards[0],
                     bus.src_dst, bus.src_regwrite, bus.src_ready);

        // Want alone never stalls ID; only a Need on an in-use operand does.
        id_need_rs = (bus.hazards[7] | bus.hazards[6]) & bus.hazards[6];
        id_need_rt = (bus.hazards[5] | bus.hazards[4]) & bus.hazards[4];

        sb_hit_rs  = 1'b0;
        sb_hit_rt  = 1'b0;
        ex_rs_sb   = 1'b0;
        ex_rt_sb   = 1'b0;
        waw        = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        ret_found  = 1'b0;
        ret_idx    = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid[i]) begin
                if (sb_dst[i] == bus.id_rs && bus.id_rs != '0) sb_hit_rs = 1'b1;
                if (sb_dst[i] == bus.id_rt && bus.id_rt != '0) sb_hit_rt = 1'b1;
                if (sb_dst[i] == bus.ex_rs && bus.ex_rs != '0) ex_rs_sb  = 1'b1;
                if (sb_dst[i] == bus.ex_rt && bus.ex_rt != '0) ex_rt_sb  = 1'b1;
                if (sb_dst[i] == bus.ex_dst && bus.ex_dst != '0) waw     = 1'b1;
                if (!ret_found && sb_cnt[i] == LAT_W'(1)) begin
                    ret_found = 1'b1;
                    ret_idx   = IDX_W'(i);
                end
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        ex_hit_rs  = bus.ex_regwrite && bus.ex_dst == bus.id_rs && bus.id_rs != '0;
        ex_hit_rt  = bus.ex_regwrite && bus.ex_dst == bus.id_rt && bus.id_rt != '0;
        id_rs_busy = ex_hit_rs | sb_hit_rs |
                     src_busy(bus.id_rs, bus.src_dst, bus.src_regwrite, bus.src_ready);
        id_rt_busy = ex_hit_rt | sb_hit_rt |
                     src_busy(bus.id_rt, bus.src_dst, bus.src_regwrite, bus.src_ready);
        id_hz      = (id_need_rs & id_rs_busy) | (id_need_rt & id_rt_busy);

        ex_hz    = rs_fwd[SEL_W] | rt_fwd[SEL_W] |
                   (bus.hazards[2] & ex_rs_sb) | (bus.hazards[0] & ex_rt_sb);
        sb_full  = &sb_valid;
        sb_stall = bus.lat_issue & (sb_full | waw);

        if_stall = bus.imem_read_en | bus.imem_ack;
        m_stall  = if_stall | bus.mem_ctrl_stall;
        ex_stall = bus.alu_stall | ex_hz | sb_stall | m_stall;
        id_stall = id_hz | ex_stall;
        issue    = bus.lat_issue & ~ex_stall;
        lat_done = ret_found & ~reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_valid  <= '0;
            stall_cnt <= '0;
            for (int unsigned i = 0; i < SB_DEPTH; i++) begin
                sb_dst[i] <= '0;
                sb_cnt[i] <= '0;
            end
        end else begin
            // Entries at 1 that lose the report arbitration hold until their turn.
            for (int unsigned i = 0; i < SB_DEPTH; i++) begin
                if (sb_valid[i]) begin
                    if (ret_found && ret_idx == IDX_W'(i)) sb_valid[i] <= 1'b0;
                    else if (sb_cnt[i] != LAT_W'(1))       sb_cnt[i]   <= sb_cnt[i] - LAT_W'(1);
                end
            end
            if (issue) begin
                sb_valid[free_idx] <= 1'b1;
                sb_dst[free_idx]   <= bus.ex_dst;
                sb_cnt[free_idx]   <= (bus.lat_cycles == '0) ? LAT_W'(1) : bus.lat_cycles;
            end
            if (id_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.ex_rs_sel    = bus.ex_link ? SEL_LINK : rs_fwd[SEL_W-1:0];
    assign bus.ex_rt_sel    = bus.ex_link ? SEL_LINK : rt_fwd[SEL_W-1:0];
    assign bus.if_stall     = if_stall;
    assign bus.m_stall      = m_stall;
    assign bus.wb_stall     = m_stall;
    assign bus.ex_stall     = ex_stall;
    assign bus.id_stall     = id_stall;
    assign bus.lat_done     = lat_done;
    assign bus.lat_done_dst = lat_done ? sb_dst[ret_idx] : '0;
    assign bus.sb_full      = sb_full;
    assign bus.stall_cnt    = stall_cnt;
endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: forwarding priority, ID/EX hazards,
// scoreboard countdown/full/WAW behaviour, stall counter and reset.
module tb_hazard_unit_sb;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clock = ~clock;

    hazard_unit_sb_if #(.REG_W(5), .NUM_SRC(2), .LAT_W(6)) hif ();

    hazard_unit_sb #(.REG_W(5), .NUM_SRC(2), .SB_DEPTH(4), .LAT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        hif.hazards        = '0;
        hif.id_rs          = '0;
        hif.id_rt          = '0;
        hif.ex_rs          = '0;
        hif.ex_rt          = '0;
        hif.ex_dst         = '0;
        hif.ex_regwrite    = 1'b0;
        hif.ex_link        = 1'b0;
        hif.src_dst        = '0;
        hif.src_regwrite   = '0;
        hif.src_ready      = '0;
        hif.lat_issue      = 1'b0;
        hif.lat_cycles     = '0;
        hif.imem_read_en   = 1'b0;
        hif.imem_ack       = 1'b0;
        hif.alu_stall      = 1'b0;
        hif.mem_ctrl_stall = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
    endtask

    initial begin
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_stall_cnt", hif.stall_cnt, 32'd0);
        check("rst_lat_done", {31'd0, hif.lat_done}, 32'd0);
        check("rst_lat_dst", {27'd0, hif.lat_done_dst}, 32'd0);
        check("rst_sb_full", {31'd0, hif.sb_full}, 32'd0);
        check("rst_id_stall", {31'd0, hif.id_stall}, 32'd0);

        // Forwarding priority: youngest source wins.
        hif.hazards      = 8'b0000_1000;
        hif.ex_rs        = 5'd8;
        hif.src_dst      = {5'd8, 5'd8};
        hif.src_regwrite = 2'b11;
        hif.src_ready    = 2'b11;
        settle();
        check("fwd_youngest", {30'd0, hif.ex_rs_sel}, 32'd1);
        hif.src_regwrite = 2'b10;
        settle();
        check("fwd_older", {30'd0, hif.ex_rs_sel}, 32'd2);
        hif.hazards = 8'b0000_0000;
        settle();
        check("fwd_unused_op", {30'd0, hif.ex_rs_sel}, 32'd0);
        hif.hazards = 8'b0000_1000;
        hif.ex_link = 1'b1;
        settle();
        check("fwd_link_rs", {30'd0, hif.ex_rs_sel}, 32'd3);
        check("fwd_link_rt", {30'd0, hif.ex_rt_sel}, 32'd3);
        hif.ex_link      = 1'b0;
        hif.ex_rs        = 5'd0;
        hif.src_dst      = {5'd0, 5'd0};
        hif.src_regwrite = 2'b11;
        settle();
        check("fwd_zero_reg", {30'd0, hif.ex_rs_sel}, 32'd0);

        // Source not ready: Need stalls, Want does not.
        clear_inputs();
        hif.hazards      = 8'b0000_0001;
        hif.ex_rt        = 5'd9;
        hif.src_dst      = {5'd0, 5'd9};
        hif.src_regwrite = 2'b01;
        hif.src_ready    = 2'b00;
        settle();
        check("nr_need_ex_stall", {31'd0, hif.ex_stall}, 32'd1);
        check("nr_need_id_stall", {31'd0, hif.id_stall}, 32'd1);
        check("nr_need_rt_sel", {30'd0, hif.ex_rt_sel}, 32'd0);
        hif.hazards = 8'b0000_0010;
        settle();
        check("nr_want_ex_stall", {31'd0, hif.ex_stall}, 32'd0);
        check("nr_want_id_stall", {31'd0, hif.id_stall}, 32'd0);

        // ID hazards from a busy source and from EX.
        hif.hazards = 8'b0100_0000;
        hif.id_rs   = 5'd9;
        settle();
        check("id_src_busy", {31'd0, hif.id_stall}, 32'd1);
        check("id_src_busy_ex", {31'd0, hif.ex_stall}, 32'd0);
        hif.hazards = 8'b1000_0000;
        settle();
        check("id_want_only", {31'd0, hif.id_stall}, 32'd0);
        clear_inputs();
        hif.hazards     = 8'b0001_0000;
        hif.id_rt       = 5'd12;
        hif.ex_dst      = 5'd12;
        hif.ex_regwrite = 1'b1;
        settle();
        check("id_ex_dep", {31'd0, hif.id_stall}, 32'd1);
        hif.id_rt  = 5'd0;
        hif.ex_dst = 5'd0;
        settle();
        check("id_ex_zero", {31'd0, hif.id_stall}, 32'd0);

        // Stall equations from raw causes.
        clear_inputs();
        hif.imem_ack = 1'b1;
        settle();
        check("imem_if", {31'd0, hif.if_stall}, 32'd1);
        check("imem_wb", {31'd0, hif.wb_stall}, 32'd1);
        check("imem_id", {31'd0, hif.id_stall}, 32'd1);
        clear_inputs();
        hif.mem_ctrl_stall = 1'b1;
        settle();
        check("memctl_if", {31'd0, hif.if_stall}, 32'd0);
        check("memctl_m", {31'd0, hif.m_stall}, 32'd1);

        // Latency-3 op to r5; ID and EX Need r5 for 3 cycles.
        do_reset();
        hif.lat_issue  = 1'b1;
        hif.lat_cycles = 6'd3;
        hif.ex_dst     = 5'd5;
        settle();
        check("l3_issue_ok", {31'd0, hif.ex_stall}, 32'd0);
        tick();
        hif.lat_issue = 1'b0;
        hif.ex_dst    = 5'd0;
        hif.hazards   = 8'b0100_0100;
        hif.id_rs     = 5'd5;
        hif.ex_rs     = 5'd5;
        settle();
        check("l3_c1_id", {31'd0, hif.id_stall}, 32'd1);
        check("l3_c1_ex_sb", {31'd0, hif.ex_stall}, 32'd1);
        check("l3_c1_done", {31'd0, hif.lat_done}, 32'd0);
        tick();
        check("l3_c2_id", {31'd0, hif.id_stall}, 32'd1);
        check("l3_c2_done", {31'd0, hif.lat_done}, 32'd0);
        tick();
        check("l3_c3_id", {31'd0, hif.id_stall}, 32'd1);
        check("l3_c3_done", {31'd0, hif.lat_done}, 32'd1);
        check("l3_c3_dst", {27'd0, hif.lat_done_dst}, 32'd5);
        tick();
        check("l3_c4_id", {31'd0, hif.id_stall}, 32'd0);
        check("l3_c4_ex", {31'd0, hif.ex_stall}, 32'd0);
        check("l3_c4_done", {31'd0, hif.lat_done}, 32'd0);

        // Fill all four slots, then a fifth issue waits for a retire.
        do_reset();
        hif.lat_issue  = 1'b1;
        hif.lat_cycles = 6'd10;
        for (int d = 1; d <= 4; d++) begin
            hif.ex_dst = 5'(d);
            tick();
        end
        hif.ex_dst = 5'd6;
        settle();
        check("full_sb_full", {31'd0, hif.sb_full}, 32'd1);
        check("full_ex_stall", {31'd0, hif.ex_stall}, 32'd1);
        check("full_no_done", {31'd0, hif.lat_done}, 32'd0);
        repeat (6) tick();
        check("full_retire0_done", {31'd0, hif.lat_done}, 32'd1);
        check("full_retire0_dst", {27'd0, hif.lat_done_dst}, 32'd1);
        check("full_retire0_stall", {31'd0, hif.ex_stall}, 32'd1);
        tick();
        check("full_after_sb_full", {31'd0, hif.sb_full}, 32'd0);
        check("full_after_stall", {31'd0, hif.ex_stall}, 32'd0);
        check("full_retire1_dst", {27'd0, hif.lat_done_dst}, 32'd2);
        tick();
        hif.lat_issue = 1'b0;
        hif.ex_dst    = 5'd0;
        hif.hazards   = 8'b0100_0000;
        hif.id_rs     = 5'd6;
        settle();
        check("full_accepted", {31'd0, hif.id_stall}, 32'd1);
        check("full_retire2_dst", {27'd0, hif.lat_done_dst}, 32'd3);

        // Two entries reach 1 together; lower slot reports first.
        do_reset();
        hif.lat_issue  = 1'b1;
        hif.ex_dst     = 5'd10;
        hif.lat_cycles = 6'd2;
        tick();
        hif.ex_dst     = 5'd11;
        hif.lat_cycles = 6'd1;
        tick();
        hif.lat_issue = 1'b0;
        settle();
        check("tie_first_done", {31'd0, hif.lat_done}, 32'd1);
        check("tie_first_dst", {27'd0, hif.lat_done_dst}, 32'd10);
        tick();
        check("tie_second_done", {31'd0, hif.lat_done}, 32'd1);
        check("tie_second_dst", {27'd0, hif.lat_done_dst}, 32'd11);
        tick();
        check("tie_idle", {31'd0, hif.lat_done}, 32'd0);

        // WAW: second write to r7 waits until the first retires; latency 0 acts as 1.
        do_reset();
        hif.lat_issue  = 1'b1;
        hif.ex_dst     = 5'd7;
        hif.lat_cycles = 6'd2;
        tick();
        hif.lat_cycles = 6'd0;
        settle();
        check("waw_stall_a", {31'd0, hif.ex_stall}, 32'd1);
        tick();
        check("waw_stall_b", {31'd0, hif.ex_stall}, 32'd1);
        check("waw_first_done", {31'd0, hif.lat_done}, 32'd1);
        tick();
        check("waw_released", {31'd0, hif.ex_stall}, 32'd0);
        check("waw_gap", {31'd0, hif.lat_done}, 32'd0);
        tick();
        hif.lat_issue = 1'b0;
        settle();
        check("lat0_done", {31'd0, hif.lat_done}, 32'd1);
        check("lat0_dst", {27'd0, hif.lat_done_dst}, 32'd7);
        tick();
        check("lat0_gone", {31'd0, hif.lat_done}, 32'd0);

        // Stall counter over 10 stalled cycles, then reset mid-countdown.
        do_reset();
        hif.hazards     = 8'b0100_0000;
        hif.id_rs       = 5'd3;
        hif.ex_dst      = 5'd3;
        hif.ex_regwrite = 1'b1;
        repeat (10) tick();
        clear_inputs();
        settle();
        check("cnt_ten", hif.stall_cnt, 32'd10);
        hif.lat_issue  = 1'b1;
        hif.ex_dst     = 5'd4;
        hif.lat_cycles = 6'd5;
        tick();
        hif.lat_issue = 1'b0;
        hif.ex_dst    = 5'd0;
        tick();
        reset = 1'b1;
        settle();
        check("rst_mid_done", {31'd0, hif.lat_done}, 32'd0);
        tick();
        reset = 1'b0;
        hif.hazards = 8'b0100_0000;
        hif.id_rs   = 5'd4;
        settle();
        check("rst_mid_cnt", hif.stall_cnt, 32'd0);
        check("rst_mid_entry", {31'd0, hif.id_stall}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rst_mid_no_done", {31'd0, hif.lat_done}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
- Parametrised successor to the fixed two-source hazard/forward controller.
- Generalises forwarding to NUM_SRC ordered pipeline sources and adds a sequential scoreboard of pending long-latency writes (DIV/MUL, variable cycles), plus a saturating stall-cycle counter.
- Sits beside ID/EX. Produces forwarding selects for EX, stalls for all stages, and scoreboard completion pulses.

Parameters:
- REG_W, 5, register-address width.
- NUM_SRC, 2, number of forwarding sources; index 0 is youngest (default 0=MEM, 1=WB).
- SB_DEPTH, 4, scoreboard entries.
- LAT_W, 6, latency-count width.
- SEL_W (localparam), clog2(NUM_SRC+2), forwarding-select width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- hazards  in  8  {WantRsID, NeedRsID, WantRtID, NeedRtID, WantRsEX, NeedRsEX, WantRtEX, NeedRtEX}.
- id_rs, id_rt  in  REG_W each  ID source registers.
- ex_rs, ex_rt, ex_dst  in  REG_W each  EX sources and destination.
- ex_regwrite  in  1  EX will write ex_dst.
- ex_link  in  1  EX is a link instruction.
- src_dst  in  NUM_SRC*REG_W  destination of each source.
- src_regwrite  in  NUM_SRC  source writes a register.
- src_ready  in  NUM_SRC  source data is forwardable (0 for a memory access still in flight).
- lat_issue  in  1  EX holds a long-latency op.
- lat_cycles  in  LAT_W  its latency.
- imem_read_en, imem_ack, alu_stall, mem_ctrl_stall  in  1 each  stall causes.
- ex_rs_sel, ex_rt_sel  out  SEL_W each  0 = register file, k+1 = source k, 2^SEL_W-1 = link.
- if_stall, id_stall, ex_stall, m_stall, wb_stall  out  1 each.
- lat_done  out  1  one-cycle completion pulse.
- lat_done_dst  out  REG_W  destination of the completing entry.
- sb_full  out  1  all scoreboard entries valid.
- stall_cnt  out  32  saturating count of id_stall cycles.

Behaviour:
- Reset: all scoreboard entries invalid; stall_cnt=0; lat_done=0; lat_done_dst=0. Combinational outputs follow inputs.
- Match rule: source k matches register r when src_regwrite[k] && src_dst[k]==r && r!=0. Register $zero never matches anything, including scoreboard entries.
- EX forwarding select:
  - ex_link forces 2^SEL_W-1.
  - Otherwise take the lowest matching k. If src_ready[k] and the operand is Want|Need, select k+1.
  - If the matching source is not ready, select 0. Additionally, if the operand is Need, assert ex_hz.
  - No match gives 0. Older matches are ignored once a younger source matches.
- ID hazard (id_hz), asserted when ID Needs Rs or Rt and any of:
  - (ex_regwrite && ex_dst==reg && reg!=0);
  - any matching source with src_ready=0;
  - any valid scoreboard entry with dst==reg.
  - Want-only operands never cause an ID stall.
- EX scoreboard hazard: ex_hz is also asserted if EX Needs Rs or Rt matching a valid entry.
- Scoreboard issue:
  - On an edge with lat_issue && !ex_stall, write {valid, ex_dst, max(lat_cycles,1)} to the lowest free slot.
  - ex_dst==0 still occupies a slot. It retires normally but never raises a hazard.
- Issue stall (sb_stall) when lat_issue and either:
  - sb_full, evaluated before this cycle's retire (conservative: no same-cycle slot reuse); or
  - ex_dst matches a valid entry (WAW, nonzero dst only).
- Countdown and retire:
  - Every valid count decrements each cycle, including during stalls.
  - An entry with count==1 asserts lat_done and lat_done_dst combinationally that cycle, then clears at the edge.
  - If several entries hit 1 together, the lowest index reports. The others hold at 1 and retire in following cycles, lowest first.
- Stall equations:
  - if_stall = imem_read_en | imem_ack.
  - m_stall = if_stall | mem_ctrl_stall.
  - wb_stall = m_stall.
  - ex_stall = alu_stall | ex_hz | sb_stall | m_stall.
  - id_stall = id_hz | ex_stall.
- stall_cnt increments each cycle id_stall=1 and saturates at 0xFFFFFFFF.
- Reset mid-operation clears pending entries. No lat_done is emitted for discarded ops.

Test Plan:
- src0={dst=8, wr, ready}, src1={dst=8, wr, ready}, EX WantRs with ex_rs=8 -> ex_rs_sel=1 (youngest wins); drop src0 regwrite -> ex_rs_sel=2.
- src0={dst=9, ready=0}, EX NeedRt with rt=9 -> ex_stall=1, id_stall=1, ex_rt_sel=0; same with WantRt only -> no stall.
- Issue lat_cycles=3, dst=5, then hold ID NeedRs with rs=5 -> id_stall high 3 cycles; lat_done=1 with lat_done_dst=5 on the 3rd cycle; stall drops after.
- Fill 4 entries, then lat_issue again -> sb_full=1, ex_stall=1; the issue is accepted the cycle after the first retire.
- Issue dst=7 while dst=7 is pending -> ex_stall until the first entry retires; lat_cycles=0 retires after 1 cycle.
- Force id_stall for 10 cycles -> stall_cnt=10; assert reset mid-countdown -> no lat_done, stall_cnt=0.
